if_fetch_ctrl: RTL and testbench

Sequences instruction fetch over the AXI read address/data channels and feeds the IF/ID pipeline register. It launches one read per PC, captures and aligns the returned instruction, and holds it while the pipeline is stalled. It drives the `handshake_done` qualifier and a PC-advance pulse. Flush and exception flush kill in-flight fetches, and their responses are discarded.

---
 rtl/if_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch sequencer. It issues one single-beat AXI read per PC, aligns
// the returned word, and holds it in the IF/ID register until decode consumes it.
// Only one transaction is ever outstanding. A flush or exception flush kills an
// in-flight fetch, and the killed response is drained and dropped.
//
// Optional feature: define FETCH_ERR_EN to add the fetch_err output. A non-OKAY
// r_resp then zeroes the captured instruction and flags fetch_err.
//
// Ports
//   cpu_clk_50M, cpu_rst      clock; synchronous active-high reset
//   fetch_en, pc_in           fetch permission and the PC to fetch
//   id_stall, data_read_stall stall sources (ORed)
//   flush, excep_flush        kill sources (ORed)
//   ar_*                      AXI read-address channel (single beat, 4 bytes)
//   r_*                       AXI read-data channel
//   if_pc, if_inst            held PC and instruction for decode
//   handshake_done            if_pc/if_inst valid this cycle
//   pc_advance                one-cycle pulse when the held instruction is consumed
//   fetch_busy                a request is outstanding (AR, R or DISCARD)
//   fetch_err                 (FETCH_ERR_EN only) held instruction came back with an error
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,   // 64 or 32 only
    parameter int unsigned AXI_ID = 0
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              id_stall,
    input  logic              data_read_stall,
    input  logic              flush,
    input  logic              excep_flush,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [3:0]        ar_id,
    output logic [7:0]        ar_len,
    output logic [2:0]        ar_size,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst,
    output logic              handshake_done,
    output logic              pc_advance,
    output logic              fetch_busy
`ifdef FETCH_ERR_EN
    ,
    output logic              fetch_err
`endif
);

    localparam int unsigned HI_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AR      = 3'd1,
        S_R       = 3'd2,
        S_HOLD    = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_kill_pend;
    logic              w_kill_pend_nxt;
    logic [HI_W-1:0]   r_ar_addr_hi;
    logic [ADDR_W-1:0] r_if_pc;
    logic [31:0]       r_if_inst;
    logic              r_handshake;
    logic              w_handshake_nxt;
    logic              w_issue;
    logic              w_capture;
    logic              w_pc_advance;
    logic              w_kill;
    logic              w_stall;
    logic [31:0]       w_inst_sel;
    logic              w_resp_err;
    logic              w_unused;

    assign w_kill  = flush | excep_flush;
    assign w_stall = id_stall | data_read_stall;

    // Pick the 32-bit instruction out of the returned beat.
    generate
        if (DATA_W == 64) begin : g_sel64
            assign w_inst_sel = r_ar_addr_hi[0] ? r_data[63:32] : r_data[31:0];
        end else begin : g_sel32
            assign w_inst_sel = r_data[31:0];
        end
    endgenerate

`ifdef FETCH_ERR_EN
    assign w_resp_err = (r_resp != 2'b00);
    assign w_unused   = ^{r_last, pc_in[1:0]};
`else
    assign w_resp_err = 1'b0;
    assign w_unused   = ^{r_last, r_resp, pc_in[1:0]};
`endif

    // State register.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_next_state    = r_state;
        w_kill_pend_nxt = r_kill_pend;
        w_handshake_nxt = r_handshake;
        w_issue         = 1'b0;
        w_capture       = 1'b0;
        w_pc_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_kill_pend_nxt = 1'b0;
                if (fetch_en && !w_kill) begin
                    w_issue      = 1'b1;
                    w_next_state = S_AR;
                end
            end
            S_AR: begin
                // A kill anywhere in the address phase (including the accept
                // cycle) dooms the response that follows.
                if (w_kill) begin
                    w_kill_pend_nxt = 1'b1;
                end
                if (ar_ready) begin
                    w_kill_pend_nxt = 1'b0;
                    w_next_state    = (w_kill || r_kill_pend) ? S_DISCARD : S_R;
                end
            end
            S_R: begin
                if (r_valid) begin
                    if (w_kill) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_capture       = 1'b1;
                        w_handshake_nxt = 1'b1;
                        w_next_state    = S_HOLD;
                    end
                end else if (w_kill) begin
                    w_next_state = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (r_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            S_HOLD: begin
                if (w_kill) begin
                    w_handshake_nxt = 1'b0;
                    w_next_state    = S_IDLE;
                end else if (!w_stall) begin
                    w_pc_advance    = 1'b1;
                    w_handshake_nxt = 1'b0;
                    w_next_state    = S_IDLE;
                end
            end
            default: begin
                w_handshake_nxt = 1'b0;
                w_next_state    = S_IDLE;
            end
        endcase
    end

    // Address latch, IF/ID capture and handshake flag.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_kill_pend  <= 1'b0;
            r_ar_addr_hi <= '0;
            r_if_pc      <= '0;
            r_if_inst    <= '0;
            r_handshake  <= 1'b0;
        end else begin
            r_kill_pend <= w_kill_pend_nxt;
            r_handshake <= w_handshake_nxt;
            if (w_issue) begin
                r_ar_addr_hi <= pc_in[ADDR_W-1:2];
            end
            if (w_capture) begin
                r_if_pc   <= {r_ar_addr_hi, 2'b00};
                r_if_inst <= w_resp_err ? 32'h0 : w_inst_sel;
            end
        end
    end

`ifdef FETCH_ERR_EN
    logic r_fetch_err;

    // Error flag lives exactly as long as the handshake it qualifies.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_fetch_err <= 1'b0;
        end else if (w_capture) begin
            r_fetch_err <= w_resp_err;
        end else if (!w_handshake_nxt) begin
            r_fetch_err <= 1'b0;
        end
    end

    assign fetch_err = r_fetch_err;
`endif

    assign ar_valid       = (r_state == S_AR);
    assign r_ready        = (r_state == S_R) || (r_state == S_DISCARD);
    assign fetch_busy     = (r_state == S_AR) || (r_state == S_R) || (r_state == S_DISCARD);
    assign ar_addr        = {r_ar_addr_hi, 2'b00};
    assign ar_id          = 4'(AXI_ID);
    assign ar_len         = 8'd0;
    assign ar_size        = 3'b010;
    assign if_pc          = r_if_pc;
    assign if_inst        = r_if_inst;
    assign handshake_done = r_handshake;
    assign pc_advance     = w_pc_advance;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Directed scenarios with literal expectations, then randomized traffic. A
// transaction-level model (pending address / pending data / doomed / holding)
// predicts every output each cycle and is compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    logic              clk = 1'b0;
    logic              cpu_rst;
    logic              fetch_en;
    logic [ADDR_W-1:0] pc_in;
    logic              id_stall;
    logic              data_read_stall;
    logic              flush;
    logic              excep_flush;
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [3:0]        ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       if_inst;
    logic              handshake_done;
    logic              pc_advance;
    logic              fetch_busy;
`ifdef FETCH_ERR_EN
    logic              fetch_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    if_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID(0)) dut (
        .cpu_clk_50M     (clk),
        .cpu_rst         (cpu_rst),
        .fetch_en        (fetch_en),
        .pc_in           (pc_in),
        .id_stall        (id_stall),
        .data_read_stall (data_read_stall),
        .flush           (flush),
        .excep_flush     (excep_flush),
        .ar_valid        (ar_valid),
        .ar_ready        (ar_ready),
        .ar_addr         (ar_addr),
        .ar_id           (ar_id),
        .ar_len          (ar_len),
        .ar_size         (ar_size),
        .r_valid         (r_valid),
        .r_ready         (r_ready),
        .r_data          (r_data),
        .r_resp          (r_resp),
        .r_last          (r_last),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .handshake_done  (handshake_done),
        .pc_advance      (pc_advance),
        .fetch_busy      (fetch_busy)
`ifdef FETCH_ERR_EN
        ,
        .fetch_err       (fetch_err)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit              m_on   = 1'b0;
    bit              m_ap   = 1'b0;   // address issued, not yet accepted
    bit              m_dp   = 1'b0;   // address accepted, data not yet returned
    bit              m_doom = 1'b0;   // outstanding fetch has been killed
    bit              m_hold = 1'b0;   // instruction held for decode
    bit              m_err  = 1'b0;
    logic [63:0]     m_addr = '0;
    logic [63:0]     m_pc   = '0;
    logic [31:0]     m_inst = '0;
    bit              m_kill;
    bit              m_stall;

    always @(negedge clk) begin
        m_kill  = flush | excep_flush;
        m_stall = id_stall | data_read_stall;
        if (m_on) begin
            chk("ar_valid", 64'(ar_valid), 64'(m_ap));
            chk("r_ready", 64'(r_ready), 64'(m_dp));
            chk("handshake_done", 64'(handshake_done), 64'(m_hold));
            chk("pc_advance", 64'(pc_advance), 64'(m_hold && !m_kill && !m_stall));
            chk("fetch_busy", 64'(fetch_busy), 64'(m_ap || m_dp));
            chk("ar_const", {44'h0, ar_id, ar_len, ar_size, 5'h0}, {44'h0, 4'h0, 8'h0, 3'b010, 5'h0});
            if (m_ap || m_dp || m_hold) chk("ar_addr", ar_addr, m_addr);
            if (m_hold) begin
                chk("if_pc", if_pc, m_pc);
                chk("if_inst", 64'(if_inst), 64'(m_inst));
            end
`ifdef FETCH_ERR_EN
            chk("fetch_err", 64'(fetch_err), 64'(m_hold && m_err));
`endif
        end
        if (cpu_rst) begin
            m_on = 1'b1; m_ap = 1'b0; m_dp = 1'b0; m_doom = 1'b0; m_hold = 1'b0;
            m_err = 1'b0; m_addr = '0; m_pc = '0; m_inst = '0;
        end else if (m_on) begin
            if (m_hold) begin
                if (m_kill || !m_stall) begin
                    m_hold = 1'b0;
                    m_err  = 1'b0;
                end
            end else if (m_ap) begin
                if (m_kill) m_doom = 1'b1;
                if (ar_ready) begin
                    m_ap = 1'b0;
                    m_dp = 1'b1;
                end
            end else if (m_dp) begin
                if (r_valid) begin
                    m_dp = 1'b0;
                    if (!m_doom && !m_kill) begin
                        m_hold = 1'b1;
                        m_pc   = m_addr;
                        m_inst = m_addr[2] ? r_data[63:32] : r_data[31:0];
                        m_err  = 1'b0;
`ifdef FETCH_ERR_EN
                        if (r_resp != 2'b00) begin
                            m_inst = 32'h0;
                            m_err  = 1'b1;
                        end
`endif
                    end
                    m_doom = 1'b0;
                end else if (m_kill) begin
                    m_doom = 1'b1;
                end
            end else if (fetch_en && !m_kill) begin
                m_ap   = 1'b1;
                m_doom = 1'b0;
                m_addr = pc_in & ~64'h3;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_in();
        fetch_en = 1'b0; pc_in = '0; id_stall = 1'b0; data_read_stall = 1'b0;
        flush = 1'b0; excep_flush = 1'b0; ar_ready = 1'b0; r_valid = 1'b0;
        r_data = '0; r_resp = 2'b00; r_last = 1'b1;
    endtask

    // Issue, accept at once, return data next cycle; ends after the R cycle.
    task automatic fetch_to_r(input logic [63:0] pc, input logic [63:0] data, input logic [1:0] resp);
        step(); clr_in(); fetch_en = 1'b1; pc_in = pc;
        sample();
        step(); fetch_en = 1'b0; ar_ready = 1'b1;
        sample(); chk("dir_ar_valid", 64'(ar_valid), 64'd1); chk("dir_ar_addr", ar_addr, pc & ~64'h3);
        step(); ar_ready = 1'b0; r_valid = 1'b1; r_data = data; r_resp = resp;
        sample(); chk("dir_r_ready", 64'(r_ready), 64'd1);
    endtask

    initial begin
        clr_in();
        cpu_rst = 1'b1;
        repeat (3) step();
        cpu_rst = 1'b0;
        sample();
        chk("rst_outputs", {60'h0, ar_valid, r_ready, handshake_done, pc_advance}, 64'h0);
        chk("rst_ar_addr", ar_addr, 64'h0);
        chk("rst_if_pc", if_pc, 64'h0);
        chk("rst_if_inst", 64'(if_inst), 64'h0);

        // Plain fetch.
        fetch_to_r(64'h8000_0004, 64'h00500093_00000013, 2'b00);
        step(); clr_in();
        sample();
        chk("plain_hs", 64'(handshake_done), 64'd1);
        chk("plain_inst", 64'(if_inst), 64'h0050_0093);
        chk("plain_pc", if_pc, 64'h8000_0004);
        chk("plain_adv", 64'(pc_advance), 64'd1);
        step(); sample();
        chk("plain_hs_drop", 64'(handshake_done), 64'd0);
        chk("plain_adv_drop", 64'(pc_advance), 64'd0);

        // Stall hold.
        fetch_to_r(64'h8000_0000, 64'h00500093_00000013, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step(); clr_in(); id_stall = 1'b1;
            sample();
            chk("stall_hs", 64'(handshake_done), 64'd1);
            chk("stall_inst", 64'(if_inst), 64'h0000_0013);
            chk("stall_adv", 64'(pc_advance), 64'd0);
        end
        step(); id_stall = 1'b0;
        sample();
        chk("stall_release_adv", 64'(pc_advance), 64'd1);
        step(); sample();
        chk("stall_after_hs", 64'(handshake_done), 64'd0);

        // Flush during AR, address accepted three cycles later.
        step(); clr_in(); fetch_en = 1'b1; pc_in = 64'h1000;
        sample();
        step(); fetch_en = 1'b0; flush = 1'b1;
        sample(); chk("flar_valid0", 64'(ar_valid), 64'd1);
        step(); flush = 1'b0;
        sample(); chk("flar_valid1", 64'(ar_valid), 64'd1);
        step();
        sample(); chk("flar_valid2", 64'(ar_valid), 64'd1);
        step(); ar_ready = 1'b1;
        sample(); chk("flar_valid3", 64'(ar_valid), 64'd1);
        step(); ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'hDEAD_BEEF_CAFE_F00D;
        sample();
        chk("flar_r_ready", 64'(r_ready), 64'd1);
        chk("flar_busy", 64'(fetch_busy), 64'd1);
        step(); r_valid = 1'b0;
        sample();
        chk("flar_no_hs", 64'(handshake_done), 64'd0);
        chk("flar_idle", 64'(fetch_busy), 64'd0);

        // Exception flush while held under a data stall.
        fetch_to_r(64'h2008, 64'h11111111_22222222, 2'b00);
        step(); clr_in(); excep_flush = 1'b1; data_read_stall = 1'b1;
        sample();
        chk("exc_hs", 64'(handshake_done), 64'd1);
        chk("exc_adv", 64'(pc_advance), 64'd0);
        chk("exc_pc", if_pc, 64'h2008);
        step(); clr_in();
        sample();
        chk("exc_hs_drop", 64'(handshake_done), 64'd0);
        chk("exc_idle", {62'h0, fetch_busy, ar_valid}, 64'h0);

        // Reset in R, then a stray r_valid in IDLE.
        step(); clr_in(); fetch_en = 1'b1; pc_in = 64'h3000;
        step(); fetch_en = 1'b0; ar_ready = 1'b1;
        step(); ar_ready = 1'b0; cpu_rst = 1'b1;
        sample(); chk("rstR_in_r", 64'(r_ready), 64'd1);
        step(); cpu_rst = 1'b0; r_valid = 1'b1; r_data = 64'h12345678_9ABCDEF0;
        sample();
        chk("rstR_outputs", {59'h0, ar_valid, r_ready, handshake_done, pc_advance, fetch_busy}, 64'h0);
        chk("rstR_ar_addr", ar_addr, 64'h0);
        chk("rstR_if_pc", if_pc, 64'h0);
        chk("rstR_if_inst", 64'(if_inst), 64'h0);
        step(); r_valid = 1'b0;
        sample();
        chk("rstR_stray_hs", 64'(handshake_done), 64'd0);
        chk("rstR_stray_busy", 64'(fetch_busy), 64'd0);

`ifdef FETCH_ERR_EN
        fetch_to_r(64'h4000, 64'hAAAAAAAA_BBBBBBBB, 2'b10);
        step(); clr_in(); id_stall = 1'b1;
        sample();
        chk("err_inst", 64'(if_inst), 64'h0);
        chk("err_flag", 64'(fetch_err), 64'd1);
        chk("err_hs", 64'(handshake_done), 64'd1);
        step(); clr_in();
`endif

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            step();
            cpu_rst         = ($urandom_range(0, 199) == 0);
            fetch_en        = ($urandom_range(0, 9) < 8);
            pc_in           = {$urandom, $urandom};
            id_stall        = ($urandom_range(0, 9) < 3);
            data_read_stall = ($urandom_range(0, 9) < 2);
            flush           = ($urandom_range(0, 15) == 0);
            excep_flush     = ($urandom_range(0, 31) == 0);
            ar_ready        = ($urandom_range(0, 1) == 1);
            r_valid         = ($urandom_range(0, 1) == 1);
            r_data          = {$urandom, $urandom};
            r_resp          = 2'($urandom_range(0, 3));
            r_last          = ($urandom_range(0, 1) == 1);
        end
        step(); clr_in();
        step();
        sample();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
